// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer, its synchronous program ROM and the control unit.
// The sequencer drives the master side; ROM and control unit sit on the slave side.
interface instr_sequencer_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [ADDR_W+4:0] rom_data;
    logic [4:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic              instr_valid;
    logic              pc_hold;

    modport master (
        output rom_addr, rom_rd, opcode, operand, instr_valid,
        input  rom_data, pc_hold
    );

    modport slave (
        input  rom_addr, rom_rd, opcode, operand, instr_valid,
        output rom_data, pc_hold
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction fetch/sequencing engine: owns the PC, fetches from a synchronous ROM,
// issues opcode/operand to the control unit and picks the next PC from its jump request.
module instr_sequencer #(
    parameter int              ADDR_W      = 11,
    parameter int              EXEC_CYCLES = 2,
    parameter logic [4:0]      HALT_OP     = 5'b10111,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    instr_sequencer_if.master bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_EXEC,
        S_HALTED
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [4:0]        opcode_q;
    logic [ADDR_W-1:0] operand_q;
    logic              rom_rd_q;
    logic              instr_valid_q;
    logic              halted_q;
    logic              jump_q;
    logic [CNT_W-1:0]  cnt_q;

    // A pc_hold seen in the final EXEC cycle still counts, so it bypasses the latch here.
    assign pc_d = (jump_q || bus.pc_hold) ? operand_q : pc_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            opcode_q      <= '0;
            operand_q     <= '0;
            rom_rd_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            jump_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge
            // state; the strobe defaults below make rom_rd/instr_valid single-cycle pulses.
            rom_rd_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q  <= S_FETCH;
                        rom_rd_q <= 1'b1;
                    end
                end
                S_FETCH: state_q <= S_WAIT;
                S_WAIT: begin
                    if (bus.rom_data[ADDR_W+4 -: 5] == HALT_OP) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        opcode_q      <= bus.rom_data[ADDR_W+4 -: 5];
                        operand_q     <= bus.rom_data[ADDR_W-1:0];
                        instr_valid_q <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    jump_q  <= bus.pc_hold;
                    cnt_q   <= CNT_W'(EXEC_CYCLES - 1);
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    jump_q <= jump_q | bus.pc_hold;
                    if (cnt_q == '0) begin
                        pc_q <= pc_d;
                        if (run) begin
                            state_q  <= S_FETCH;
                            rom_rd_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.rom_rd      = rom_rd_q;
    assign bus.opcode      = opcode_q;
    assign bus.operand     = operand_q;
    assign bus.instr_valid = instr_valid_q;
    assign pc              = pc_q;
    assign halted          = halted_q;
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction fetch and sequencing engine that feeds the 16-bit CPU's control unit. It owns the program counter and fetches instruction words from a synchronous program ROM. It splits each word into a 5-bit opcode and an 11-bit operand, issues them to the control unit, then consumes the control unit's `pc_hold` (jump request) to choose the next PC. It stops permanently on the halt opcode.

## Interface
- `ADDR_W`, 11: PC / operand width; instruction word is `5 + ADDR_W` bits.
- `EXEC_CYCLES`, 2: cycles reserved for the control unit to execute an issued instruction (≥1).
- `HALT_OP`, 5'b10111: opcode that halts sequencing.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `run`  in  1: enable; sampled only in IDLE and at instruction boundaries.
- `rom_data`  in  16: ROM read data, valid the cycle after `rom_rd`.
- `pc_hold`  in  1: jump request from the control unit; when asserted, next PC becomes the operand.
- `rom_addr`  out  ADDR_W: ROM address, always equal to `pc`.
- `rom_rd`  out  1: ROM read strobe.
- `pc`  out  ADDR_W: current program counter.
- `opcode`  out  5: issued opcode, held until next issue.
- `operand`  out  ADDR_W: issued operand/target, held until next issue.
- `instr_valid`  out  1: one-cycle issue pulse.
- `halted`  out  1: sticky halt indicator.

## Operation
- Instruction word: `[15:11]` opcode, `[10:0]` operand.
- States: IDLE, FETCH, WAIT, ISSUE, EXEC, HALTED.
- IDLE: if `run`=1, go to FETCH next cycle; otherwise stay in IDLE.
- FETCH: `rom_rd`=1 for one cycle at address `pc`; go to WAIT.
- WAIT: register `rom_data` at the end of the cycle.
  - If the opcode equals `HALT_OP`, go to HALTED. The instruction is not issued, `opcode`/`operand` are not updated, and `pc` is unchanged.
  - Otherwise, load `opcode`/`operand` and go to ISSUE.
- ISSUE: `instr_valid`=1 for exactly one cycle; clear the jump latch; go to EXEC.
- EXEC: runs for `EXEC_CYCLES` cycles using a down-counter.
  - The jump latch is set if `pc_hold`=1 in any ISSUE or EXEC cycle, i.e. sticky OR.
  - The `pc` update happens at the end of the last EXEC cycle:
    - jump latch or `pc_hold` set: `pc` = `operand`;
    - otherwise: `pc` = `pc`+1, modulo 2^ADDR_W (`pc`=2^ADDR_W−1 wraps to 0).
  - After the last EXEC cycle, go to FETCH if `run`=1, else IDLE.
- `run` deasserted mid-instruction: the current instruction completes, including the PC update; the FSM stops in IDLE. Sequencing resumes at the updated `pc` when `run` returns.
- HALTED: absorbing; `halted`=1, `rom_rd`=0, `instr_valid`=0. `run` is ignored; only `rst_n` exits.
- A jump to its own address (`operand` = `pc`) is legal and loops forever.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `rom_addr`=`RESET_PC`;
  - `rom_rd`=0, `instr_valid`=0, `halted`=0;
  - `opcode`=0, `operand`=0;
  - state IDLE, jump latch 0, EXEC counter 0.
- Reset is asynchronous on the `rst_n` falling edge. Asserting it mid-instruction abandons the instruction with no PC update. Release is synchronous to the next `clk` edge.
- Instruction period with `run` held high: 3 + `EXEC_CYCLES` cycles (default 5). FETCH→WAIT→ISSUE→EXEC×N.
- `instr_valid` rises exactly 2 cycles after `rom_rd`.
- `pc` changes only on the edge ending the last EXEC cycle, or on reset. It is stable throughout FETCH/WAIT/ISSUE.
- `pc_hold` asserted only in FETCH, WAIT or IDLE is ignored.
- `halted` rises on the edge ending WAIT of the halt instruction: 2 cycles after its `rom_rd`.
- All outputs are registered except `rom_addr`, which is a wire equal to `pc`.

## Test plan
- Reset and start:
  - Stimulus: `rst_n` low, then high with `run`=0 for 3 cycles, then `run`=1.
  - Required response: all outputs at reset values during the 3 cycles; first `rom_rd` with `rom_addr`=0 one cycle after `run` rises.
- Sequential execution:
  - Stimulus: ROM[0..2] = opcode 00000/01101/10000, operands 0x005/0x006/0x007; `pc_hold`=0.
  - Required response: `instr_valid` pulses 5 cycles apart; `opcode`/`operand` match each word; `pc` steps 0→1→2→3.
- Jump taken:
  - Stimulus: ROM[4] = {10100, 0x123}; `pc_hold` pulsed for 1 cycle in the second EXEC cycle.
  - Required response: next `rom_addr`=0x123. Repeat with `pc_hold`=0 → next `rom_addr`=5.
- Wrap-around:
  - Stimulus: `RESET_PC`=0x7FF, ROM[0x7FF] non-jump, ROM[0]=HALT.
  - Required response: `pc` goes 0x7FF→0x000; then `halted`=1 and `pc` stays 0.
- Halt behaviour:
  - Stimulus: ROM[3]=HALT; `run` toggled after halt.
  - Required response: no `instr_valid` for the HALT word; `rom_rd` stays 0; `opcode` retains the previous value; `halted` stays 1 until `rst_n` is asserted.
- Run and reset mid-instruction:
  - Stimulus: drop `run` during EXEC of instruction 1.
  - Required response: `pc`=2 after the instruction completes; FSM stays in IDLE with no `rom_rd`.
  - Stimulus: assert `rst_n` low during EXEC.
  - Required response: `pc` returns to `RESET_PC` immediately, without waiting for a clock edge.
